// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display capture block:
// segment patterns (active-low, {g,f,e,d,c,b,a}), FSM state encoding,
// the code stored for undecodable patterns, and small digit-enable helpers.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] CODE_INVALID = 4'hF;
    localparam logic [3:0] AN_BLANK     = 4'b1111;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // True when exactly one digit enable is driven low.
    function automatic logic onehot_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    // Slot number selected by a one-hot-low enable pattern.
    function automatic logic [1:0] slot_of(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to digit-code translation.
// Decodes 0..9 always; A..F only when SEG_HEX_DECODE_EN is defined.
// Anything else yields CODE_INVALID with valid low.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       valid
);

    // Look up the digit value for the active-low cathode pattern.
    always_comb begin
        code  = CODE_INVALID;
        valid = 1'b0;
        case (pattern)
            SEG_0: begin code = 4'h0; valid = 1'b1; end
            SEG_1: begin code = 4'h1; valid = 1'b1; end
            SEG_2: begin code = 4'h2; valid = 1'b1; end
            SEG_3: begin code = 4'h3; valid = 1'b1; end
            SEG_4: begin code = 4'h4; valid = 1'b1; end
            SEG_5: begin code = 4'h5; valid = 1'b1; end
            SEG_6: begin code = 4'h6; valid = 1'b1; end
            SEG_7: begin code = 4'h7; valid = 1'b1; end
            SEG_8: begin code = 4'h8; valid = 1'b1; end
            SEG_9: begin code = 4'h9; valid = 1'b1; end
`ifdef SEG_HEX_DECODE_EN
            SEG_A: begin code = 4'hA; valid = 1'b1; end
            SEG_B: begin code = 4'hB; valid = 1'b1; end
            SEG_C: begin code = 4'hC; valid = 1'b1; end
            SEG_D: begin code = 4'hD; valid = 1'b1; end
            SEG_E: begin code = 4'hE; valid = 1'b1; end
            SEG_F: begin code = 4'hF; valid = 1'b1; end
`endif
            default: begin
                code  = CODE_INVALID;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_display_capture.sv
// Recovers the four digits shown on a multiplexed seven-segment display by
// sniffing its active-low digit enables and cathodes. A digit is captured
// once its {an,seven} sample has been stable for STABLE_CYCLES cycles; a
// frame is published when all four slots have been captured.
// Optional feature: define SEG_HEX_DECODE_EN to also decode A..F.
module seg_display_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seven,
    output logic [15:0] digits,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic        err_multi
);

    localparam logic [7:0] STABLE_TH = 8'(STABLE_CYCLES);

    logic [3:0]  an_p0;
    logic [6:0]  seven_p0;
    logic [3:0]  an_p1;
    logic [6:0]  seven_p1;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic        hold;
    logic        same;
    logic        blank;
    logic        go_cap;
    logic [3:0]  cap_an;
    logic [6:0]  cap_seven;

    logic [3:0]  mask;
    logic [3:0]  pend;
    logic [15:0] slot_buf;
    logic [3:0]  dec_code;
    logic        dec_valid;

    seg_pattern_decode u_decode (
        .pattern (cap_seven),
        .code    (dec_code),
        .valid   (dec_valid)
    );

    // Input stage: register the raw pins, then keep the previous sample for comparison.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_p0    <= AN_BLANK;
            seven_p0 <= SEG_OFF;
            an_p1    <= AN_BLANK;
            seven_p1 <= SEG_OFF;
        end else begin
            an_p0    <= an;
            seven_p0 <= seven;
            an_p1    <= an_p0;
            seven_p1 <= seven_p0;
        end
    end

    // Stability count for the current sample and the decision to capture it.
    // 'hold' blocks a second capture of a window that was already captured.
    always_comb begin
        same     = ({an_p0, seven_p0} == {an_p1, seven_p1});
        blank    = (an_p0 == AN_BLANK);
        cnt_next = 8'd1;
        if (state == SETTLE && same) begin
            cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
        go_cap = !blank && (state != CAPTURE) &&
                 (cnt_next >= STABLE_TH) && !(hold && same);
    end

    // Capture FSM: IDLE while blanked, SETTLE while counting, CAPTURE for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            hold      <= 1'b0;
            cap_an    <= AN_BLANK;
            cap_seven <= SEG_OFF;
        end else begin
            if (state == CAPTURE) begin
                hold <= same;
            end else if (!same) begin
                hold <= 1'b0;
            end
            case (state)
                IDLE, SETTLE: begin
                    if (blank) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt_next;
                        if (go_cap) begin
                            state     <= CAPTURE;
                            cap_an    <= an_p0;
                            cap_seven <= seven_p0;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Frame assembly: fill slot buffers on capture, publish once all four are in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask        <= 4'b0000;
            pend        <= 4'b0000;
            slot_buf    <= 16'h0000;
            digits      <= 16'h0000;
            invalid     <= 4'b0000;
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (mask == 4'b1111) begin
                digits      <= slot_buf;
                invalid     <= pend;
                frame_valid <= 1'b1;
                mask        <= 4'b0000;
                pend        <= 4'b0000;
            end else if (state == CAPTURE) begin
                if (onehot_low(cap_an)) begin
                    slot_buf[4*slot_of(cap_an) +: 4] <= dec_code;
                    pend[slot_of(cap_an)]            <= !dec_valid;
                    mask[slot_of(cap_an)]            <= 1'b1;
                end else begin
                    err_multi <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_capture.sv
// Self-checking bench for seg_display_capture (STABLE_CYCLES = 4).
// Expected frames are queued as stimulus is driven and compared when
// frame_valid pulses. Build with SEG_HEX_DECODE_EN to exercise hex decode.
module tb_seg_display_capture;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  inv;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  seven = 7'b1111111;
    logic [15:0] digits;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        err_multi;

    int tests = 0;
    int fails = 0;
    frame_t exp_q[$];

    seg_display_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seven       (seven),
        .digits      (digits),
        .invalid     (invalid),
        .frame_valid (frame_valid),
        .err_multi   (err_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pat_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int slot, input logic [6:0] p, input int n);
        logic [3:0] sel;
        sel   = 4'b1111;
        sel[slot] = 1'b0;
        an    = sel;
        seven = p;
        tick(n);
    endtask

    task automatic blank(input int n);
        an    = 4'b1111;
        seven = 7'b1111111;
        tick(n);
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] inv);
        frame_t f;
        f.d   = d;
        f.inv = inv;
        exp_q.push_back(f);
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest queued frame.
    initial begin
        frame_t f;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(frame_valid), 32'd0);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_digits", 32'(digits), 32'(f.d));
                    check("frame_invalid", 32'(invalid), 32'(f.inv));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;

        // Reset state
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_invalid", 32'(invalid), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_err_multi", 32'(err_multi), 32'h0);
        blank(3);

        // Plain scan 1,2,3,4 on slots 0..3
        push(16'h4321, 4'b0000);
        for (int i = 0; i < 4; i++) show(i, pat_of(i + 1), 8);
        blank(4);

        // Slot 2 all-off, others zero
        push(16'h0F00, 4'b0100);
        for (int i = 0; i < 4; i++) show(i, (i == 2) ? 7'b1111111 : pat_of(0), 8);
        blank(4);

        // Re-capture of slot 0 overwrites without completing the frame
        push(16'h8657, 4'b0000);
        show(0, pat_of(1), 8);
        show(0, pat_of(7), 8);
        show(1, pat_of(5), 8);
        show(2, pat_of(6), 8);
        show(3, pat_of(8), 8);
        blank(4);

        // Two enables low: error flag, no capture into slots 0/1
        show(2, pat_of(1), 8);
        show(3, pat_of(2), 8);
        blank(2);
        check("err_before_multi", 32'(err_multi), 32'h0);
        an    = 4'b1100;
        seven = pat_of(5);
        tick(8);
        blank(4);
        check("err_after_multi", 32'(err_multi), 32'h1);
        push(16'h2143, 4'b0000);
        show(0, pat_of(3), 8);
        show(1, pat_of(4), 8);
        blank(4);

        // Segments toggling faster than the stability window: nothing captured
        show(1, pat_of(6), 8);
        show(2, pat_of(7), 8);
        show(3, pat_of(8), 8);
        for (int i = 0; i < 10; i++) show(0, pat_of(i % 2), 2);
        blank(4);
        push(16'h8769, 4'b0000);
        show(0, pat_of(9), 8);
        blank(4);
        check("err_sticky", 32'(err_multi), 32'h1);

        // Long hold captures once; frame still needs the other slots
        push(16'h1115, 4'b0000);
        show(0, pat_of(5), 40);
        show(1, pat_of(1), 8);
        show(2, pat_of(1), 8);
        show(3, pat_of(1), 8);
        blank(4);

        // Reset mid-frame discards partial captures and clears the error flag
        for (int i = 0; i < 3; i++) show(i, pat_of(5), 8);
        blank(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_invalid", 32'(invalid), 32'h0);
        check("midrst_err_multi", 32'(err_multi), 32'h0);
        blank(3);
        push(16'h9999, 4'b0000);
        for (int i = 0; i < 4; i++) show(i, pat_of(9), 8);
        blank(4);

        // Pattern for 'A' on every slot
`ifdef SEG_HEX_DECODE_EN
        push(16'hAAAA, 4'b0000);
`else
        push(16'hFFFF, 4'b1111);
`endif
        for (int i = 0; i < 4; i++) show(i, 7'b0001000, 8);
        blank(4);

        // Drain: every queued frame must have appeared
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 30) begin
            tick(1);
            wait_cnt++;
        end
        check("frames_outstanding", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_capture.md
SEG_DISPLAY_CAPTURE -- requirements
Module: seg_display_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required before a digit is captured (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port an, input, 4, digit enables, active-low, an[i]=0 selects digit slot i.
REQ-005 SHALL have port seven, input, 7, segment cathodes, active-low, bit order {g,f,e,d,c,b,a} (bit0=a).
REQ-006 SHALL have port digits, output, 16, last complete frame; digits[4i+3:4i] is slot i.
REQ-007 SHALL have port invalid, output, 4, per-slot flag meaning the pattern in the last frame was undecodable.
REQ-008 SHALL have port frame_valid, output, 1, one-cycle pulse when digits/invalid update.
REQ-009 SHALL have port err_multi, output, 1, sticky flag meaning more than one an bit was low during a stable window.

Function
REQ-010 SHALL register an and seven once per cycle before any comparison (input latency 1 cycle).
REQ-011 SHALL implement states IDLE, SETTLE, CAPTURE.
REQ-012 SHALL stay in IDLE while the registered an is 4'b1111 (blanking).
REQ-013 SHALL move IDLE->SETTLE on any an value other than 4'b1111 and load the stability counter with 1.
REQ-014 SHALL in SETTLE increment the counter when registered {an,seven} equals the previous cycle's value, and reload to 1 on any change.
REQ-015 SHALL go SETTLE->CAPTURE when the counter reaches STABLE_CYCLES; SETTLE->IDLE if an returns to 4'b1111.
REQ-016 SHALL in CAPTURE, if an is one-hot-low, decode seven into slot buffer i, set mask bit i, and return to IDLE on the next cycle regardless of an.
REQ-017 SHALL in CAPTURE, if an has two or more low bits, set err_multi, capture nothing, return to IDLE.
REQ-018 SHALL decode patterns 0..9 as 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
REQ-019 SHALL store 4'hF and set the slot's pending invalid bit for any undecodable pattern (including all-off 1111111).
REQ-020 SHALL let a re-capture of an already-masked slot overwrite it (latest wins) without completing a frame.
REQ-021 SHALL, on the cycle after the mask becomes 4'b1111, copy slot buffers to digits, pending bits to invalid, pulse frame_valid, and clear mask and pending bits.
REQ-022 SHALL hold digits and invalid constant between frame_valid pulses.
REQ-023 SHALL allow at most one capture per stable window; a digit held indefinitely captures once until an changes.

Reset
REQ-024 SHALL on rst_n=0 at a clock edge force: state IDLE, counter 0, mask 0, slot buffers 0, digits 16'h0000, invalid 4'b0000, frame_valid 0, err_multi 0.
REQ-025 SHALL discard a partially captured frame on reset mid-frame; no frame_valid until four fresh captures follow reset release.
REQ-026 SHALL clear err_multi only by reset.

Configuration
REQ-027 SHALL, when SEG_HEX_DECODE_EN is defined, additionally decode A..F as 0001000,0000011,1000110,0100001,0000110,0001110 to 4'hA..4'hF with invalid cleared.
REQ-028 SHALL, when SEG_HEX_DECODE_EN is undefined, treat those six patterns as undecodable per REQ-019.

Structure
REQ-029 SHALL place the segment pattern constants, the state enum, and the invalid code 4'hF in a shared package seg_pkg.
REQ-030 SHALL implement pattern-to-code translation in one combinational sub-module seg_pattern_decode (7-bit in, 4-bit code plus valid out), instantiated once.

Verification
REQ-031 SHALL cover: scan slots 0..3 with patterns for 1,2,3,4, each held 8 cycles, STABLE_CYCLES=4 -> one frame_valid, digits=16'h4321, invalid=0.
REQ-032 SHALL cover: slot 2 pattern 1111111, others valid 0 -> digits[11:8]=4'hF, invalid=4'b0100.
REQ-033 SHALL cover: an=4'b1100 held 8 cycles -> err_multi=1, no mask change, no frame_valid.
REQ-034 SHALL cover: segment toggled every 2 cycles with STABLE_CYCLES=4 -> no capture, mask unchanged.
REQ-035 SHALL cover: rst_n low for one cycle after 3 captures, then 4 captures of 9 -> exactly one frame_valid, digits=16'h9999.
REQ-036 SHALL cover: pattern 0001000 on all slots -> 16'hAAAA, invalid=0 with SEG_HEX_DECODE_EN; 16'hFFFF, invalid=4'b1111 without.
